// File: rtl/fetch_ctrl_if.sv
// Fetch record type and instruction-bus interface for fetch_ctrl.
// Defining FETCH_MISALIGN_EN adds the exc_misalign bit to fetch_data_t.
package fetch_ctrl_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
`ifdef FETCH_MISALIGN_EN
        logic        exc_misalign;
`endif
    } fetch_data_t;
endpackage

interface fetch_ctrl_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, one-entry stall buffer and redirect draining.
// Optional feature macro FETCH_MISALIGN_EN: misaligned PCs fault instead of being force-aligned.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stallF,
    input  logic                redirect_valid,
    input  logic [63:0]         redirect_target,
    fetch_ctrl_if.master        ibus,
    output fetch_data_t         dataF
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
`ifdef FETCH_MISALIGN_EN
        , FAULT
`endif
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_pend;
    logic [63:0] r_hold_pc;
    logic [31:0] r_hold_instr;
    fetch_data_t r_dataf;

    state_t      w_state_n;
    logic [63:0] w_pc_n;
    logic [63:0] w_pend_n;
    logic [63:0] w_hold_pc_n;
    logic [31:0] w_hold_instr_n;
    fetch_data_t w_dataf_n;
    logic [63:0] w_tgt;
    logic        w_req;
    logic        w_misalign;

    function automatic logic [63:0] pc_plus4(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

    function automatic logic [63:0] load_target(input logic [63:0] tgt);
`ifdef FETCH_MISALIGN_EN
        return tgt;
`else
        return {tgt[63:2], 2'b00};
`endif
    endfunction

    function automatic fetch_data_t make_rec(input logic [63:0] pc, input logic [31:0] instr);
        fetch_data_t rec;
        rec           = '0;
        rec.valid     = 1'b1;
        rec.pc        = pc;
        rec.raw_instr = instr;
        return rec;
    endfunction

    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_pend_n       = r_pend;
        w_hold_pc_n    = r_hold_pc;
        w_hold_instr_n = r_hold_instr;
        w_dataf_n      = r_dataf;
        w_req          = 1'b0;
        w_tgt          = load_target(redirect_target);
        w_misalign     = 1'b0;
`ifdef FETCH_MISALIGN_EN
        w_misalign     = (r_pc[1:0] != 2'b00);
`endif
        // A redirect always kills the delivery slot and any buffered instruction.
        if (redirect_valid) begin
            w_dataf_n      = '0;
            w_hold_pc_n    = '0;
            w_hold_instr_n = '0;
        end
        case (r_state)
            FETCH: begin
                w_req = !w_misalign;
                if (redirect_valid) begin
                    if (ibus.iresp_data_ok || w_misalign) begin
                        w_pc_n = w_tgt;
                    end else begin
                        w_pend_n  = w_tgt;
                        w_state_n = DRAIN;
                    end
                end else if (w_misalign) begin
`ifdef FETCH_MISALIGN_EN
                    if (!stallF) begin
                        w_dataf_n              = make_rec(r_pc, NOP_INSTR);
                        w_dataf_n.exc_misalign = 1'b1;
                        w_state_n              = FAULT;
                    end
`endif
                end else if (ibus.iresp_data_ok) begin
                    w_pc_n = pc_plus4(r_pc);
                    if (stallF) begin
                        w_hold_pc_n    = r_pc;
                        w_hold_instr_n = ibus.iresp_data;
                        w_state_n      = HOLD;
                    end else begin
                        w_dataf_n = make_rec(r_pc, ibus.iresp_data);
                    end
                end else if (!stallF) begin
                    w_dataf_n = '0;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_pc_n    = w_tgt;
                    w_state_n = FETCH;
                end else if (!stallF) begin
                    w_dataf_n      = make_rec(r_hold_pc, r_hold_instr);
                    w_hold_pc_n    = '0;
                    w_hold_instr_n = '0;
                    w_state_n      = FETCH;
                end
            end
            DRAIN: begin
                // The old address stays on the bus until its response is swallowed.
                w_req = 1'b1;
                if (redirect_valid) begin
                    if (ibus.iresp_data_ok) begin
                        w_pc_n    = w_tgt;
                        w_pend_n  = '0;
                        w_state_n = FETCH;
                    end else begin
                        w_pend_n = w_tgt;
                    end
                end else begin
                    if (ibus.iresp_data_ok) begin
                        w_pc_n    = r_pend;
                        w_pend_n  = '0;
                        w_state_n = FETCH;
                    end
                    if (!stallF) begin
                        w_dataf_n = '0;
                    end
                end
            end
`ifdef FETCH_MISALIGN_EN
            FAULT: begin
                if (redirect_valid) begin
                    w_pc_n    = w_tgt;
                    w_state_n = FETCH;
                end else if (!stallF) begin
                    w_dataf_n = '0;
                end
            end
`endif
            default: begin
                w_state_n = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= FETCH;
            r_pc         <= PC_RESET;
            r_pend       <= '0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
            r_dataf      <= '0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_pend       <= w_pend_n;
            r_hold_pc    <= w_hold_pc_n;
            r_hold_instr <= w_hold_instr_n;
            r_dataf      <= w_dataf_n;
        end
    end

    assign ibus.ireq_valid = w_req & ~reset;
    assign ibus.ireq_addr  = r_pc;
    assign dataF           = r_dataf;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl; outputs are compared one time unit after inputs change.
// Expected values for the misaligned-redirect rows follow FETCH_MISALIGN_EN.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        stallF;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    fetch_data_t dataF;

    fetch_ctrl_if bus();

    fetch_ctrl #(.PC_RESET(64'h0000_0000_8000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stallF          (stallF),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ibus            (bus),
        .dataF           (dataF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [63:0] rt;
        logic        ok;
        logic [31:0] data;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_dv;
        logic        chk;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_exc;
    } vec_t;

    vec_t vt[$];
    int   n_checks;
    int   n_fail;

    localparam logic [63:0] B = 64'h0000_0000_8000_0000;

    task automatic addv(input logic rst, input logic stall, input logic rv, input logic [63:0] rt,
                        input logic ok, input logic [31:0] data, input logic e_req,
                        input logic [63:0] e_addr, input logic e_dv, input logic chk,
                        input logic [63:0] e_pc, input logic [31:0] e_instr, input logic e_exc);
        vec_t v;
        v.rst = rst; v.stall = stall; v.rv = rv; v.rt = rt; v.ok = ok; v.data = data;
        v.e_req = e_req; v.e_addr = e_addr; v.e_dv = e_dv; v.chk = chk;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_exc = e_exc;
        vt.push_back(v);
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic rv, input logic [63:0] rt,
                         input logic ok, input logic [31:0] data);
        reset              = rst;
        stallF             = stall;
        redirect_valid     = rv;
        redirect_target    = rt;
        bus.iresp_data_ok  = ok;
        bus.iresp_data     = data;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic get_exc(input fetch_data_t d);
`ifdef FETCH_MISALIGN_EN
        return d.exc_misalign;
`else
        return (d.valid === 1'bx);
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Streaming after reset with same-cycle responses, then a bubble.
        addv(1,0,0,0,0,0,                 0, B,        0,1, 0,        32'h0,         0);
        addv(0,0,0,0,1,32'h1111_1111,     1, B,        0,1, 0,        32'h0,         0);
        addv(0,0,0,0,1,32'h2222_2222,     1, B+4,      1,1, B,        32'h1111_1111, 0);
        addv(0,0,0,0,1,32'h3333_3333,     1, B+8,      1,1, B+4,      32'h2222_2222, 0);
        addv(0,0,0,0,0,0,                 1, B+12,     1,1, B+8,      32'h3333_3333, 0);
        addv(1,0,0,0,0,0,                 0, B+12,     0,0, 0,        0,             0);
        // Stall while the response at B+4 arrives: held in the buffer for three cycles.
        addv(0,0,0,0,1,32'h1111_1111,     1, B,        0,1, 0,        32'h0,         0);
        addv(0,1,0,0,1,32'h0010_0093,     1, B+4,      1,1, B,        32'h1111_1111, 0);
        addv(0,1,0,0,1,32'hDEAD_DEAD,     0, B+8,      1,1, B,        32'h1111_1111, 0);
        addv(0,1,0,0,0,0,                 0, B+8,      1,1, B,        32'h1111_1111, 0);
        addv(0,0,0,0,0,0,                 0, B+8,      1,1, B,        32'h1111_1111, 0);
        addv(0,0,0,0,0,0,                 1, B+8,      1,1, B+4,      32'h0010_0093, 0);
        // Redirect while B+8 is outstanding; its response lands two cycles later.
        addv(0,0,1,B+64'h100,0,0,         1, B+8,      0,0, 0,        0,             0);
        addv(0,0,0,0,0,0,                 1, B+8,      0,0, 0,        0,             0);
        addv(0,0,0,0,1,32'h4444_4444,     1, B+8,      0,0, 0,        0,             0);
        addv(0,0,0,0,1,32'h5555_5555,     1, B+64'h100,0,0, 0,        0,             0);
        addv(0,0,0,0,1,32'h5A5A_5A5A,     1, B+64'h104,1,1, B+64'h100,32'h5555_5555, 0);
        // Redirect beats stallF in the same cycle.
        addv(0,1,1,B+64'h200,1,32'h6666_6666, 1, B+64'h108,1,1, B+64'h104,32'h5A5A_5A5A, 0);
        addv(0,1,0,0,0,0,                 1, B+64'h200,0,0, 0,        0,             0);
        // Reset while holding a buffered instruction.
        addv(0,1,0,0,1,32'h7777_7777,     1, B+64'h200,0,0, 0,        0,             0);
        addv(1,1,0,0,1,32'h7777_7777,     0, B+64'h204,0,0, 0,        0,             0);
        addv(0,0,0,0,0,0,                 1, B,        0,1, 0,        32'h0,         0);
        addv(0,0,0,0,0,0,                 1, B,        0,0, 0,        0,             0);
        // Redirect to a misaligned target.
        addv(0,0,1,B+64'h102,1,32'h8888_8888, 1, B,   0,0, 0,        0,             0);
`ifdef FETCH_MISALIGN_EN
        addv(0,0,0,0,0,0,                 0, B+64'h102,0,0, 0,        0,             0);
        addv(0,0,0,0,0,0,                 0, B+64'h102,1,1, B+64'h102,32'h0000_0013, 1);
`else
        addv(0,0,0,0,0,0,                 1, B+64'h100,0,0, 0,        0,             0);
        addv(0,0,0,0,0,0,                 1, B+64'h100,0,0, 0,        0,             0);
`endif

        drive(1,0,0,0,0,0);
        tick();
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].stall, vt[i].rv, vt[i].rt, vt[i].ok, vt[i].data);
            check($sformatf("row%0d.ireq_valid", i), {63'd0, bus.ireq_valid}, {63'd0, vt[i].e_req});
            check($sformatf("row%0d.ireq_addr", i),  bus.ireq_addr, vt[i].e_addr);
            check($sformatf("row%0d.valid", i),      {63'd0, dataF.valid}, {63'd0, vt[i].e_dv});
            if (vt[i].chk) begin
                check($sformatf("row%0d.pc", i),    dataF.pc, vt[i].e_pc);
                check($sformatf("row%0d.instr", i), {32'd0, dataF.raw_instr}, {32'd0, vt[i].e_instr});
                check($sformatf("row%0d.exc", i),   {63'd0, get_exc(dataF)}, {63'd0, vt[i].e_exc});
            end
            tick();
        end

        // Back-to-back redirects while draining: the last target wins.
        drive(1,0,0,0,0,0);
        tick();
        drive(0,0,1,B+64'h300,0,0);
        check("drain1.addr", bus.ireq_addr, B);
        tick();
        drive(0,0,1,B+64'h400,0,0);
        check("drain2.req", {63'd0, bus.ireq_valid}, 64'd1);
        check("drain2.addr", bus.ireq_addr, B);
        tick();
        drive(0,0,0,0,1,32'hDEAD_BEEF);
        check("drain3.addr", bus.ireq_addr, B);
        tick();
        drive(0,0,0,0,0,0);
        check("drain4.addr", bus.ireq_addr, B+64'h400);
        check("drain4.valid", {63'd0, dataF.valid}, 64'd0);
        tick();

        // PC increment wraps modulo 2^64.
        drive(0,0,1,64'hFFFF_FFFF_FFFF_FFFC,1,32'h0);
        tick();
        drive(0,0,0,0,1,32'hCAFE_0001);
        check("wrap1.addr", bus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        drive(0,0,0,0,0,0);
        check("wrap2.addr", bus.ireq_addr, 64'h0);
        check("wrap2.valid", {63'd0, dataF.valid}, 64'd1);
        check("wrap2.pc", dataF.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap2.instr", {32'd0, dataF.raw_instr}, 64'h0000_0000_CAFE_0001);
        tick();

        // Reset in the middle of a drain, with a response arriving during reset.
        drive(0,0,1,B+64'h500,0,0);
        tick();
        drive(1,0,0,0,1,32'h1234_5678);
        check("rstdrain1.req", {63'd0, bus.ireq_valid}, 64'd0);
        tick();
        drive(0,0,0,0,0,0);
        check("rstdrain2.req", {63'd0, bus.ireq_valid}, 64'd1);
        check("rstdrain2.addr", bus.ireq_addr, B);
        check("rstdrain2.valid", {63'd0, dataF.valid}, 64'd0);
        tick();
        drive(0,0,0,0,0,0);
        check("rstdrain3.addr", bus.ireq_addr, B);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
